sprite_scheduler: RTL

- Per-frame controller that sequences the single sprite renderer feeding framebuffer write port 1.
- Holds a double-buffered sprite table: a shadow copy written by the host and an active copy used for rendering.
- On each frame start (falling edge of global vsync) it copies shadow to active, then walks the active entries in index order.
- For each enabled entry it issues one render command and waits for completion before moving to the next.

---
 rtl/sprite_pkg.sv | 29 ++
 rtl/sprite_scheduler_if.sv | 27 ++
 rtl/sprite_table.sv | 51 +++++
 rtl/sprite_scheduler.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// sprite_pkg: shared types for the sprite scheduler.
// Table entry layout, screen bounds, FSM states.
package sprite_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  typedef struct packed {
    logic       en;
    logic [9:0] x;
    logic [8:0] y;
    logic [3:0] id;
  } sprite_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_WAIT,
    ST_DONE
  } sched_state_t;

  function automatic logic on_screen(
    sprite_entry_t e
  );
    return (e.x < 10'(SCREEN_W)) &&
           (e.y < 9'(SCREEN_H));
  endfunction

endpackage

// File: rtl/sprite_scheduler_if.sv
// sprite_scheduler_if: render command handshake.
// master = scheduler (start + operands), slave = renderer (done).
interface sprite_scheduler_if;

  logic       rnd_start;
  logic [9:0] rnd_x;
  logic [8:0] rnd_y;
  logic [3:0] rnd_id;
  logic       rnd_done;

  modport master (
    output rnd_start,
    output rnd_x,
    output rnd_y,
    output rnd_id,
    input  rnd_done
  );

  modport slave (
    input  rnd_start,
    input  rnd_x,
    input  rnd_y,
    input  rnd_id,
    output rnd_done
  );

endinterface

// File: rtl/sprite_table.sv
// sprite_table: shadow (host-written) and active sprite tables.
// Ports: wr_* shadow write, copy shadow->active, rd_idx/rd_entry read.
module sprite_table
  import sprite_pkg::*;
#(
  parameter  int MAX_SPRITES = 16,
  localparam int IDX_W = $clog2(MAX_SPRITES)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  sprite_entry_t    wr_entry,
  input  logic             copy,
  input  logic [IDX_W-1:0] rd_idx,
  output sprite_entry_t    rd_entry
);

  sprite_entry_t shadow [MAX_SPRITES];
  sprite_entry_t active [MAX_SPRITES];
  sprite_entry_t wr_q;

  // off-screen entries are stored but never drawn
  always_comb begin
    wr_q    = wr_entry;
    wr_q.en = wr_entry.en & on_screen(wr_entry);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < MAX_SPRITES; i++)
        shadow[i] <= '0;
    end else if (wr_en) begin
      shadow[wr_addr] <= wr_q;
    end
  end

  // copy sees the pre-write shadow, so a same-cycle
  // write lands in the following frame
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < MAX_SPRITES; i++)
        active[i] <= '0;
    end else if (copy) begin
      active <= shadow;
    end
  end

  assign rd_entry = active[rd_idx];

endmodule

// File: rtl/sprite_scheduler.sv
// sprite_scheduler: per-frame walk of the sprite table driving the renderer.
// Ports: clock/reset_n, enable, vsync, tbl_* writes, rnd (master), status/err.
module sprite_scheduler
  import sprite_pkg::*;
#(
  parameter  int MAX_SPRITES = 16,
  parameter  int TIMEOUT = 1024,
  localparam int IDX_W = $clog2(MAX_SPRITES)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               vsync,
  input  logic               tbl_we,
  input  logic [IDX_W-1:0]   tbl_addr,
  input  sprite_entry_t      tbl_entry,
  sprite_scheduler_if.master rnd,
  output logic               frame_busy,
  output logic               frame_done,
  output logic [IDX_W:0]     sprites_drawn,
  output logic [7:0]         overrun_cnt,
  output logic               timeout_err,
  input  logic               err_clr
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST =
    IDX_W'(MAX_SPRITES - 1);

  sched_state_t     state;
  logic [IDX_W-1:0] idx;
  logic [TW-1:0]    wcnt;
  logic [IDX_W:0]   acc;
  logic             vsync_q;
  sprite_entry_t    cur;

  logic frame_start;
  logic copy;
  logic done_ok;
  logic tmo;
  logic last;

  assign frame_start = vsync_q & ~vsync;
  assign copy = (state == ST_IDLE) &
                frame_start & enable;
  // done in the start cycle belongs to no command
  assign done_ok = rnd.rnd_done & ~rnd.rnd_start;
  assign tmo = (state == ST_WAIT) & ~done_ok &
               (wcnt == TW'(TIMEOUT - 1));
  assign last = (idx == LAST);

  sprite_table #(
    .MAX_SPRITES(MAX_SPRITES)
  ) u_table (
    .clock    (clock),
    .reset_n  (reset_n),
    .wr_en    (tbl_we),
    .wr_addr  (tbl_addr),
    .wr_entry (tbl_entry),
    .copy     (copy),
    .rd_idx   (idx),
    .rd_entry (cur)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      idx           <= '0;
      wcnt          <= '0;
      acc           <= '0;
      vsync_q       <= 1'b1;
      rnd.rnd_start <= 1'b0;
      rnd.rnd_x     <= '0;
      rnd.rnd_y     <= '0;
      rnd.rnd_id    <= '0;
      frame_busy    <= 1'b0;
      frame_done    <= 1'b0;
      sprites_drawn <= '0;
      overrun_cnt   <= '0;
      timeout_err   <= 1'b0;
    end else begin
      vsync_q       <= vsync;
      rnd.rnd_start <= 1'b0;
      frame_done    <= 1'b0;

      if (frame_start && enable &&
          state != ST_IDLE &&
          overrun_cnt != 8'hff)
        overrun_cnt <= overrun_cnt + 8'd1;

      if (err_clr)
        timeout_err <= 1'b0;
      else if (tmo)
        timeout_err <= 1'b1;

      unique case (state)
        ST_IDLE: begin
          if (copy) begin
            idx        <= '0;
            acc        <= '0;
            frame_busy <= 1'b1;
            state      <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (cur.en) begin
            rnd.rnd_x     <= cur.x;
            rnd.rnd_y     <= cur.y;
            rnd.rnd_id    <= cur.id;
            rnd.rnd_start <= 1'b1;
            wcnt          <= '0;
            state         <= ST_WAIT;
          end else if (last) begin
            state <= ST_DONE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        ST_WAIT: begin
          if (done_ok || tmo) begin
            if (done_ok)
              acc <= acc + (IDX_W + 1)'(1);
            if (last) begin
              state <= ST_DONE;
            end else begin
              idx   <= idx + IDX_W'(1);
              state <= ST_SCAN;
            end
          end else begin
            wcnt <= wcnt + TW'(1);
          end
        end
        ST_DONE: begin
          frame_done    <= 1'b1;
          sprites_drawn <= acc;
          frame_busy    <= 1'b0;
          state         <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
